ct_f_spsram_pipe: RTL and testbench

CT_F_SPSRAM_PIPE -- requirements
Module: ct_f_spsram_pipe

---
 rtl/ct_f_spsram_pipe.sv | 166 ++++++++++++++++
 tb/tb_ct_f_spsram_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_pipe.sv
// ct_f_spsram_pipe: single-port synchronous SRAM with read-first behaviour,
// per-bit active-low write enables and an optional output pipeline register.
//
// Parameters:
//   ADDR_WIDTH - word address width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH - word width in bits
//   OUT_REG    - 1 adds an output register stage (read latency 2 instead of 1)
//
// Ports:
//   CLK       - clock, all state on rising edge
//   RST_B     - asynchronous active-low reset
//   A         - word address
//   CEN       - chip enable, active low
//   GWEN      - global write enable, active low (1 = read)
//   WEN       - per-bit write enable, active low
//   D         - write data
//   Q         - read data (old contents on a write access)
//   INIT_DONE - memory accepts accesses
//
// Configuration macro CT_F_SPSRAM_INIT_CLEAR_EN: when defined, every reset
// release runs a clear sequence (IDLE -> CLEAR -> READY) that writes zero to
// all words before INIT_DONE rises. When undefined, contents survive reset and
// INIT_DONE rises on the first clock edge after reset release.
//
// Reset release is only ever observed at a CLK edge: all flops that leave
// reset load their first non-reset value synchronously.

module ct_f_spsram_pipe #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_DONE
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];

    logic                  init_done_q;
    logic                  access;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_wmask;

    logic [DATA_WIDTH-1:0] rdata_q;

    assign access    = ~CEN & init_done_q;
    assign INIT_DONE = init_done_q;

`ifdef CT_F_SPSRAM_INIT_CLEAR_EN
    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StReady
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q     <= StIdle;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q    <= StClear;
                    clr_addr_q <= '0;
                end
                StClear: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    // Last word is written on this edge.
                    if (&clr_addr_q) begin
                        state_q     <= StReady;
                        init_done_q <= 1'b1;
                    end
                end
                StReady: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state_q == StClear);
    assign clr_addr = clr_addr_q;
`else
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // Clear and user accesses are mutually exclusive: access needs init_done_q.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = A;
        mem_wdata = D;
        mem_wmask = ~WEN;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = '0;
            mem_wmask = '1;
        end else if (access && !GWEN) begin
            mem_we = 1'b1;
        end
    end

    // Array is never reset so it can map onto block RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    // Read-first: captures the pre-write word on every access, holds otherwise.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            rdata_q <= '0;
        end else if (access) begin
            rdata_q <= mem[A];
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_pipe_q;

        always_ff @(posedge CLK or negedge RST_B) begin
            if (!RST_B) begin
                q_pipe_q <= '0;
            end else begin
                q_pipe_q <= rdata_q;
            end
        end

        assign Q = q_pipe_q;
    end else begin : g_no_out_reg
        assign Q = rdata_q;
    end

endmodule

// File: tb/tb_ct_f_spsram_pipe.sv
// Self-checking bench for ct_f_spsram_pipe. Two instances share all inputs:
// dut0 with OUT_REG=0 and dut1 with OUT_REG=1. Each issued access pushes its
// expected read data into one queue per instance; a monitor pops and compares
// when the access result is due at that instance's latency.
// Also runs under CT_F_SPSRAM_INIT_CLEAR_EN (clear-sequence checks enabled).

module tb_ct_f_spsram_pipe;

    localparam int unsigned Aw = 4;
    localparam int unsigned Dw = 8;

`ifdef CT_F_SPSRAM_INIT_CLEAR_EN
    localparam bit Macro    = 1'b1;
    localparam int ReadyLat = 17;
`else
    localparam bit Macro    = 1'b0;
    localparam int ReadyLat = 1;
`endif

    typedef struct packed {
        logic [Dw-1:0] val;
        logic          care;
    } exp_t;

    logic          CLK;
    logic          RST_B;
    logic [Aw-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [Dw-1:0] WEN;
    logic [Dw-1:0] D;
    logic [Dw-1:0] q0;
    logic [Dw-1:0] q1;
    logic          done0;
    logic          done1;

    exp_t sb0[$];
    exp_t sb1[$];
    logic issue;
    logic v1;
    logic v2;

    int n_checks = 0;
    int n_pass   = 0;

    ct_f_spsram_pipe #(
        .ADDR_WIDTH(Aw),
        .DATA_WIDTH(Dw),
        .OUT_REG   (0)
    ) dut0 (
        .CLK      (CLK),
        .RST_B    (RST_B),
        .A        (A),
        .CEN      (CEN),
        .GWEN     (GWEN),
        .WEN      (WEN),
        .D        (D),
        .Q        (q0),
        .INIT_DONE(done0)
    );

    ct_f_spsram_pipe #(
        .ADDR_WIDTH(Aw),
        .DATA_WIDTH(Dw),
        .OUT_REG   (1)
    ) dut1 (
        .CLK      (CLK),
        .RST_B    (RST_B),
        .A        (A),
        .CEN      (CEN),
        .GWEN     (GWEN),
        .WEN      (WEN),
        .D        (D),
        .Q        (q1),
        .INIT_DONE(done1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Result-due markers: v1 for OUT_REG=0, v2 for OUT_REG=1.
    always @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= issue;
            v2 <= v1;
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (v1) begin
            if (sb0.size() == 0) begin
                check("sb0_underflow", 32'd0, 32'd1);
            end else begin
                e = sb0.pop_front();
                if (e.care) check("q0_data", {24'd0, q0}, {24'd0, e.val});
            end
        end
        if (v2) begin
            if (sb1.size() == 0) begin
                check("sb1_underflow", 32'd0, 32'd1);
            end else begin
                e = sb1.pop_front();
                if (e.care) check("q1_data", {24'd0, q1}, {24'd0, e.val});
            end
        end
    end

    task automatic set_idle();
        CEN   = 1'b1;
        GWEN  = 1'b1;
        WEN   = '1;
        D     = '0;
        issue = 1'b0;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic acc(input logic [Aw-1:0] a, input logic wr, input logic [Dw-1:0] d,
                       input logic [Dw-1:0] wen, input logic [Dw-1:0] exp, input logic care);
        A     = a;
        CEN   = 1'b0;
        GWEN  = ~wr;
        D     = d;
        WEN   = wen;
        issue = 1'b1;
        sb0.push_back('{val: exp, care: care});
        sb1.push_back('{val: exp, care: care});
        @(negedge CLK);
        set_idle();
    endtask

    // Called at the negedge of reset release; drives an access that must be ignored.
    task automatic wait_ready(input int exp_lat);
        int n;
        n    = 0;
        A    = 4'd3;
        CEN  = 1'b0;
        GWEN = 1'b0;
        D    = 8'hEE;
        WEN  = 8'h00;
        do begin
            @(negedge CLK);
            n++;
            check("q0_not_ready", {24'd0, q0}, 32'd0);
            check("q1_not_ready", {24'd0, q1}, 32'd0);
        end while (!(done0 && done1) && n < 100);
        set_idle();
        check("init_latency", n, exp_lat);
        check("init_done_match", {31'd0, done0}, {31'd0, done1});
    endtask

    initial begin
        RST_B = 1'b0;
        A     = '0;
        set_idle();
        repeat (2) @(negedge CLK);
        check("rst_q0", {24'd0, q0}, 32'd0);
        check("rst_q1", {24'd0, q1}, 32'd0);
        check("rst_done0", {31'd0, done0}, 32'd0);
        check("rst_done1", {31'd0, done1}, 32'd0);

        RST_B = 1'b1;
        wait_ready(ReadyLat);

        // Basic write/read and partial write, read-first.
        acc(4'd3, 1'b1, 8'hA5, 8'h00, 8'h00, Macro);
        acc(4'd3, 1'b0, 8'h00, 8'hFF, 8'hA5, 1'b1);
        acc(4'd3, 1'b1, 8'hFF, 8'hF0, 8'hA5, 1'b1);
        acc(4'd3, 1'b0, 8'h00, 8'hFF, 8'hAF, 1'b1);

        // Idle hold.
        repeat (5) begin
            @(negedge CLK);
            check("hold_q0", {24'd0, q0}, 32'hAF);
            check("hold_q1", {24'd0, q1}, 32'hAF);
        end

        // Back-to-back traffic.
        acc(4'd0, 1'b1, 8'h10, 8'h00, 8'h00, Macro);
        acc(4'd1, 1'b1, 8'h11, 8'h00, 8'h00, Macro);
        acc(4'd2, 1'b1, 8'h12, 8'h00, 8'h00, Macro);
        acc(4'd0, 1'b0, 8'h00, 8'hFF, 8'h10, 1'b1);
        acc(4'd1, 1'b0, 8'h00, 8'hFF, 8'h11, 1'b1);
        acc(4'd2, 1'b0, 8'h00, 8'hFF, 8'h12, 1'b1);
        acc(4'd1, 1'b1, 8'h5A, 8'h0F, 8'h11, 1'b1);
        acc(4'd1, 1'b0, 8'h00, 8'hFF, 8'h51, 1'b1);
        // Top address, no aliasing onto address 0.
        acc(4'd15, 1'b1, 8'hC3, 8'h00, 8'h00, Macro);
        acc(4'd15, 1'b0, 8'h00, 8'hFF, 8'hC3, 1'b1);
        acc(4'd0, 1'b0, 8'h00, 8'hFF, 8'h10, 1'b1);
        repeat (3) @(negedge CLK);

        // Asynchronous reset assertion mid-cycle.
        #1 RST_B = 1'b0;
        #1;
        check("arst_q0", {24'd0, q0}, 32'd0);
        check("arst_q1", {24'd0, q1}, 32'd0);
        check("arst_done0", {31'd0, done0}, 32'd0);
        @(negedge CLK);
        RST_B = 1'b1;
        wait_ready(ReadyLat);

        // Retained (or cleared) contents; address 3 was targeted while not ready.
        acc(4'd3, 1'b0, 8'h00, 8'hFF, Macro ? 8'h00 : 8'hAF, 1'b1);
        acc(4'd1, 1'b0, 8'h00, 8'hFF, Macro ? 8'h00 : 8'h51, 1'b1);
        acc(4'd15, 1'b0, 8'h00, 8'hFF, Macro ? 8'h00 : 8'hC3, 1'b1);

`ifdef CT_F_SPSRAM_INIT_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            acc(i[Aw-1:0], 1'b0, 8'h00, 8'hFF, 8'h00, 1'b1);
        end
        acc(4'd7, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b1);
        repeat (3) @(negedge CLK);
        // Reset while the clear counter sits at address 7.
        RST_B = 1'b0;
        @(negedge CLK);
        RST_B = 1'b1;
        repeat (8) @(negedge CLK);
        check("midclear_done", {31'd0, done0}, 32'd0);
        RST_B = 1'b0;
        @(negedge CLK);
        RST_B = 1'b1;
        wait_ready(17);
        acc(4'd7, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b1);
`endif

        repeat (3) @(negedge CLK);
        check("sb0_empty", sb0.size(), 32'd0);
        check("sb1_empty", sb1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
